// File: rtl/hazard_control_if.sv
// Pipeline <-> hazard unit bundle: the three stage instructions plus the
// stall/flush/forward controls and the load-use event counter.
interface hazard_control_if;
    logic [31:0] instruction_id;
    logic [31:0] instruction_ex;
    logic [31:0] instruction_wb;
    logic        if_valid;
    logic        branch_taken_ex;
    logic        stall_if;
    logic        stall_id;
    logic        bubble_ex;
    logic        flush_id;
    logic        flush_ex;
    logic [1:0]  fwd_a_sel;
    logic [1:0]  fwd_b_sel;
    logic [15:0] stall_count;

    modport master (
        output instruction_id, instruction_ex, instruction_wb, if_valid, branch_taken_ex,
        input  stall_if, stall_id, bubble_ex, flush_id, flush_ex, fwd_a_sel, fwd_b_sel,
               stall_count
    );

    modport slave (
        input  instruction_id, instruction_ex, instruction_wb, if_valid, branch_taken_ex,
        output stall_if, stall_id, bubble_ex, flush_id, flush_ex, fwd_a_sel, fwd_b_sel,
               stall_count
    );
endinterface

// File: rtl/hazard_control.sv
// RV32 five-stage hazard unit: load-use stall, taken-branch flush and
// EX/WB operand forwarding, with shadow valid bits tracking real instructions.
module hazard_control #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES      = 2
) (
    input  logic            clk,
    input  logic            rst,
    hazard_control_if.slave hc
);
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;

    localparam logic [2:0] LS_INIT = 3'(LOAD_STALL_CYCLES - 1);
    localparam logic [2:0] FL_INIT = 3'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {RUN, LSTALL, FLUSH} state_t;

    function automatic logic writes_rd(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LD) || (op == OP_LUI) ||
               (op == OP_AUIPC) || (op == OP_JAL) || (op == OP_JALR);
    endfunction

    function automatic logic uses_rs1(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I) || (op == OP_LD) || (op == OP_ST) ||
               (op == OP_BR) || (op == OP_JALR);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == OP_R) || (op == OP_ST) || (op == OP_BR);
    endfunction

    state_t      state_q;
    logic [2:0]  cnt_q;
    logic        id_v, ex_v, wb_v;
    logic [15:0] stall_count_q;

    logic [6:0] op_id, op_ex, op_wb;
    logic [4:0] rs1_id, rs2_id, rd_ex, rd_wb;

    assign op_id  = hc.instruction_id[6:0];
    assign rs1_id = hc.instruction_id[19:15];
    assign rs2_id = hc.instruction_id[24:20];
    assign op_ex  = hc.instruction_ex[6:0];
    assign rd_ex  = hc.instruction_ex[11:7];
    assign op_wb  = hc.instruction_wb[6:0];
    assign rd_wb  = hc.instruction_wb[11:7];

    logic unused_bits;
    assign unused_bits = ^{hc.instruction_id[31:25], hc.instruction_id[14:7],
                           hc.instruction_ex[31:12], hc.instruction_wb[31:12]};

    // A load's data is not ready in EX, so it never forwards from there.
    logic ex_fwd_ok, wb_fwd_ok;
    assign ex_fwd_ok = ex_v && writes_rd(op_ex) && (op_ex != OP_LD) && (rd_ex != 5'd0);
    assign wb_fwd_ok = wb_v && writes_rd(op_wb) && (rd_wb != 5'd0);

    assign hc.fwd_a_sel = (ex_fwd_ok && rd_ex == rs1_id) ? 2'b01 :
                          (wb_fwd_ok && rd_wb == rs1_id) ? 2'b10 : 2'b00;
    assign hc.fwd_b_sel = (ex_fwd_ok && rd_ex == rs2_id) ? 2'b01 :
                          (wb_fwd_ok && rd_wb == rs2_id) ? 2'b10 : 2'b00;

    logic load_use;
    assign load_use = ex_v && id_v && (op_ex == OP_LD) && (rd_ex != 5'd0) &&
                      ((uses_rs1(op_id) && rs1_id == rd_ex) ||
                       (uses_rs2(op_id) && rs2_id == rd_ex));

    logic stall, fl_id, fl_ex;

    always_comb begin
        stall = 1'b0;
        fl_id = 1'b0;
        fl_ex = 1'b0;
        if (hc.branch_taken_ex) begin
            fl_id = 1'b1;
            fl_ex = 1'b1;
        end else begin
            case (state_q)
                RUN:     stall = load_use;
                LSTALL:  stall = 1'b1;
                FLUSH:   fl_id = 1'b1;
                default: ;
            endcase
        end
    end

    assign hc.stall_if    = stall;
    assign hc.stall_id    = stall;
    assign hc.bubble_ex   = stall;
    assign hc.flush_id    = fl_id;
    assign hc.flush_ex    = fl_ex;
    assign hc.stall_count = stall_count_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= RUN;
            cnt_q         <= 3'd0;
            id_v          <= 1'b0;
            ex_v          <= 1'b0;
            wb_v          <= 1'b0;
            stall_count_q <= 16'd0;
        end else begin
            wb_v <= ex_v;
            ex_v <= id_v & ~stall & ~fl_ex;
            if (fl_id)
                id_v <= 1'b0;
            else if (!stall)
                id_v <= hc.if_valid;

            if (hc.branch_taken_ex) begin
                // Branch wins over any stall; a repeat branch restarts the flush window.
                state_q <= (FLUSH_CYCLES > 1) ? FLUSH : RUN;
                cnt_q   <= (FLUSH_CYCLES > 1) ? FL_INIT : 3'd0;
            end else begin
                case (state_q)
                    RUN: begin
                        if (load_use) begin
                            if (stall_count_q != 16'hFFFF)
                                stall_count_q <= stall_count_q + 16'd1;
                            if (LOAD_STALL_CYCLES > 1) begin
                                state_q <= LSTALL;
                                cnt_q   <= LS_INIT;
                            end
                        end
                    end
                    LSTALL, FLUSH: begin
                        cnt_q <= cnt_q - 3'd1;
                        if (cnt_q <= 3'd1)
                            state_q <= RUN;
                    end
                    default: state_q <= RUN;
                endcase
            end
        end
    end
endmodule

// File: doc/hazard_control.md
HAZARD_CONTROL -- requirements
Module: hazard_control

Interface
REQ-001 Parameter LOAD_STALL_CYCLES, default 1, range 1-7: bubble cycles inserted per load-use hazard.
REQ-002 Parameter FLUSH_CYCLES, default 2, range 1-7: cycles flush_id is held after a taken branch.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-low reset; sampled on the rising clk edge.
REQ-005 instruction_id  input  32  instruction currently in the ID stage.
REQ-006 instruction_ex  input  32  instruction currently in the EX stage.
REQ-007 instruction_wb  input  32  instruction currently in the WB stage.
REQ-008 if_valid  input  1  the IF stage is presenting a real instruction this cycle.
REQ-009 branch_taken_ex  input  1  the branch or jump in EX resolved as taken.
REQ-010 stall_if, stall_id  output  1 each  hold the IF/ID pipeline registers.
REQ-011 bubble_ex  output  1  load a NOP into the ID/EX register.
REQ-012 flush_id, flush_ex  output  1 each  squash the ID or EX slot.
REQ-013 fwd_a_sel, fwd_b_sel  output  2 each  operand source select: 00 = register file, 01 = EX result, 10 = WB result.
REQ-014 stall_count  output  16  number of load-use hazard events; saturates at 0xFFFF.

Function
REQ-015 Field decode: opcode = [6:0], rd = [11:7], rs1 = [19:15], rs2 = [24:20].
REQ-016 Writes rd: opcodes 0110011, 0010011, 0000011, 0110111, 0010111, 1101111, 1100111.
REQ-017 Uses rs1: opcodes 0110011, 0010011, 0000011, 0100011, 1100011, 1100111.
REQ-018 Uses rs2: opcodes 0110011, 0100011, 1100011.
REQ-019 rd = x0 never creates a hazard or a forward.
REQ-020 Any slot whose shadow valid bit is 0 never creates a hazard or a forward.
REQ-021 Shadow valid bits, updated each edge:
- id_v <= if_valid when stall_id = 0, otherwise id_v holds.
- id_v <= 0 when flush_id = 1.
- ex_v <= id_v & ~bubble_ex & ~flush_ex.
- wb_v <= ex_v.
REQ-022 Forwarding is combinational.
- fwd_a_sel = 01 when EX is valid, writes rd, is not a load, and its rd equals the ID rs1.
- Otherwise fwd_a_sel = 10 when WB is valid, writes rd, and its rd equals the ID rs1.
- Otherwise fwd_a_sel = 00.
- fwd_b_sel follows the same rules using the ID rs2.
- EX has priority over WB.
REQ-023 Load-use hazard: EX is valid, EX opcode = 0000011, ID is valid, and EX rd matches an ID source that the ID opcode uses.
REQ-024 FSM states: RUN, LSTALL, FLUSH; state is registered, outputs are Mealy.
REQ-025 RUN, load-use hazard, no branch:
- stall_if = stall_id = bubble_ex = 1 in the same cycle.
- stall_count increments by 1.
- If LOAD_STALL_CYCLES > 1, go to LSTALL with counter = LOAD_STALL_CYCLES - 1.
REQ-026 LSTALL:
- stall_if = stall_id = bubble_ex = 1.
- Counter decrements each cycle.
- Return to RUN in the cycle the counter reaches 0.
- A hazard detected during LSTALL is not counted again.
REQ-027 branch_taken_ex = 1 in any state:
- flush_id = flush_ex = 1 in that cycle.
- Stalls are deasserted.
- The load-use hazard is ignored.
- If FLUSH_CYCLES > 1, go to FLUSH with counter = FLUSH_CYCLES - 1; otherwise go to RUN.
REQ-028 FLUSH:
- flush_id = 1, flush_ex = 0, stalls = 0.
- Counter decrements each cycle; go to RUN in the cycle it reaches 0.
- A new branch_taken_ex reloads the counter per REQ-027.
REQ-029 Branch has priority over a load-use hazard arriving in the same cycle; stall_count does not increment in that cycle.
REQ-030 When no hazard, flush or stall condition is active, all control outputs other than the forward selects are 0.

Reset
REQ-031 While rst = 0 at an edge:
- state = RUN and all counters = 0.
- id_v = ex_v = wb_v = 0.
- stall_count = 0.
REQ-032 During and after reset, all control outputs are 0 and fwd selects are 00 until valid instructions propagate.
REQ-033 Reset asserted while in LSTALL or FLUSH aborts the sequence with no residual stall or flush in the following cycle.

Verification
REQ-034 Load-use:
- Stimulus: EX = lw x5,0(x1) (valid), ID = add x6,x5,x2 (valid), LOAD_STALL_CYCLES = 1.
- Response: stall_if = stall_id = bubble_ex = 1 for exactly 1 cycle; stall_count 0 -> 1; then, with lw in WB, fwd_a_sel = 10.
REQ-035 Forward priority:
- Stimulus: EX = addi x3,x0,1, WB = addi x3,x0,2, ID = sub x4,x3,x3.
- Response: fwd_a_sel = fwd_b_sel = 01; no stall.
REQ-036 x0 and validity:
- Stimulus: EX = lw x0,0(x1), ID = add x1,x0,x0.
- Response: no stall; fwd selects 00.
- Same check with EX carrying a real hazard but ex_v = 0.
REQ-037 Branch priority:
- Stimulus: branch_taken_ex = 1 in the same cycle as a load-use hazard, FLUSH_CYCLES = 2.
- Response: flush_id = flush_ex = 1 in cycle 0; flush_id only in cycle 1; RUN in cycle 2; stall_count unchanged.
REQ-038 Reset mid-stall:
- Stimulus: LOAD_STALL_CYCLES = 3, rst = 0 asserted in the 2nd stall cycle.
- Response: all outputs 0 on the next edge; state RUN; stall_count = 0.
REQ-039 Saturation:
- Stimulus: force 65,536 load-use events.
- Response: stall_count holds at 0xFFFF.
